// File: rtl/fft_peak_search.sv
// fft_peak_search
//   Frame-level peak detector placed after the CoreFFT output port. It
//   requests each finished frame, computes re^2+im^2 for every bin, and keeps
//   the largest power with its bin index and the sum of all bin powers. At
//   frame end the results are presented through a PEAK_VALID/PEAK_ACK
//   handshake.
//
// Ports
//   CLK, NGRST             clock (rising edge) and asynchronous active-low reset
//   OUTP_READY / READ_OUTP FFT frame available / one-cycle readout request
//   DATAO_VALID/RE/IM      one signed complex bin per valid cycle
//   SCALE_EXP              FFT block exponent, captured with bin 0
//   PEAK_VALID / PEAK_ACK  result handshake; results held until acknowledged
//   PEAK_PWR / PEAK_BIN    largest bin power and its index
//   PWR_SUM / PEAK_EXP     summed frame power and the captured exponent
//   OVERRUN                sticky: bin data arrived outside frame collection
module fft_peak_search #(
    parameter int POINTS = 256,
    parameter int WIDTH  = 18,
    parameter int SEXPW  = 4,
    localparam int LOGPTS = $clog2(POINTS),
    localparam int PWRW   = 2 * WIDTH + 1,
    localparam int SUMW   = PWRW + LOGPTS
) (
    input  logic                    CLK,
    input  logic                    NGRST,
    input  logic                    OUTP_READY,
    output logic                    READ_OUTP,
    input  logic                    DATAO_VALID,
    input  logic signed [WIDTH-1:0] DATAO_RE,
    input  logic signed [WIDTH-1:0] DATAO_IM,
    input  logic [SEXPW-1:0]        SCALE_EXP,
    output logic                    PEAK_VALID,
    input  logic                    PEAK_ACK,
    output logic [PWRW-1:0]         PEAK_PWR,
    output logic [LOGPTS-1:0]       PEAK_BIN,
    output logic [SUMW-1:0]         PWR_SUM,
    output logic [SEXPW-1:0]        PEAK_EXP,
    output logic                    OVERRUN
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [LOGPTS-1:0] LAST_BIN = LOGPTS'(POINTS - 1);

    state_t                   state_q;
    logic [LOGPTS-1:0]        bin_q;
    logic                     flush_q;
    logic [SEXPW-1:0]         exp_q;
    logic                     read_outp_q;
    logic                     peak_valid_q;
    logic [PWRW-1:0]          out_pwr_q;
    logic [LOGPTS-1:0]        out_bin_q;
    logic [SUMW-1:0]          out_sum_q;
    logic [SEXPW-1:0]         out_exp_q;
    logic                     overrun_q;

    // Pipeline stage 1 (bin power) and stage 2 (peak / sum tracking).
    logic                     s1_vld_q;
    logic                     s1_first_q;
    logic [LOGPTS-1:0]        s1_bin_q;
    logic [PWRW-1:0]          s1_pwr_q;
    logic [PWRW-1:0]          peak_pwr_q;
    logic [LOGPTS-1:0]        peak_bin_q;
    logic [SUMW-1:0]          sum_q;

    logic                     accept;
    logic signed [2*WIDTH-1:0] re_sq;
    logic signed [2*WIDTH-1:0] im_sq;
    logic [PWRW-1:0]          pwr_d;

    assign accept = DATAO_VALID && (state_q == S_COLLECT);

    // Squares are never negative, so their MSB is always 0 even for the
    // most negative input; adding them as unsigned in PWRW bits is exact.
    assign re_sq = DATAO_RE * DATAO_RE;
    assign im_sq = DATAO_IM * DATAO_IM;
    assign pwr_d = {1'b0, re_sq} + {1'b0, im_sq};

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            flush_q      <= 1'b0;
            exp_q        <= '0;
            read_outp_q  <= 1'b0;
            peak_valid_q <= 1'b0;
            out_pwr_q    <= '0;
            out_bin_q    <= '0;
            out_sum_q    <= '0;
            out_exp_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples values from before this edge, regardless of
            // statement order.
            read_outp_q <= 1'b0;

            if (DATAO_VALID && (state_q != S_COLLECT)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (OUTP_READY && !peak_valid_q) begin
                        read_outp_q <= 1'b1;
                        bin_q       <= '0;
                        state_q     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (bin_q == '0) begin
                            exp_q <= SCALE_EXP;
                        end
                        bin_q <= bin_q + LOGPTS'(1);
                        if (bin_q == LAST_BIN) begin
                            flush_q <= 1'b0;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Two cycles: the last bin passes stage 1, then stage 2.
                    if (flush_q) begin
                        out_pwr_q    <= peak_pwr_q;
                        out_bin_q    <= peak_bin_q;
                        out_sum_q    <= sum_q;
                        out_exp_q    <= exp_q;
                        peak_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (PEAK_ACK) begin
                        peak_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Power pipeline. Bin 0 reloads peak and sum, so no per-frame clear is
    // needed between frames.
    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_bin_q   <= '0;
            s1_pwr_q   <= '0;
            peak_pwr_q <= '0;
            peak_bin_q <= '0;
            sum_q      <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_first_q <= (bin_q == '0);
                s1_bin_q   <= bin_q;
                s1_pwr_q   <= pwr_d;
            end
            if (s1_vld_q) begin
                // Strict compare: on a tie the earlier (lower) bin is kept.
                if (s1_first_q || (s1_pwr_q > peak_pwr_q)) begin
                    peak_pwr_q <= s1_pwr_q;
                    peak_bin_q <= s1_bin_q;
                end
                sum_q <= s1_first_q ? SUMW'(s1_pwr_q) : sum_q + SUMW'(s1_pwr_q);
            end
        end
    end

    assign READ_OUTP  = read_outp_q;
    assign PEAK_VALID = peak_valid_q;
    assign PEAK_PWR   = out_pwr_q;
    assign PEAK_BIN   = out_bin_q;
    assign PWR_SUM    = out_sum_q;
    assign PEAK_EXP   = out_exp_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_fft_peak_search.sv
// Testbench for fft_peak_search (POINTS=8, WIDTH=8). Directed frames are
// driven from one initial block; expected results are computed from the
// driven bins, pushed to a scoreboard queue and compared when PEAK_VALID rises.
module tb_fft_peak_search;

    localparam int POINTS = 8;
    localparam int WIDTH  = 8;
    localparam int SEXPW  = 4;
    localparam int LOGPTS = 3;
    localparam int PWRW   = 2 * WIDTH + 1;
    localparam int SUMW   = PWRW + LOGPTS;

    typedef struct {
        int pwr;
        int bin;
        int sum;
        int exp;
    } result_t;

    logic                    CLK = 1'b0;
    logic                    NGRST;
    logic                    OUTP_READY;
    logic                    READ_OUTP;
    logic                    DATAO_VALID;
    logic signed [WIDTH-1:0] DATAO_RE;
    logic signed [WIDTH-1:0] DATAO_IM;
    logic [SEXPW-1:0]        SCALE_EXP;
    logic                    PEAK_VALID;
    logic                    PEAK_ACK;
    logic [PWRW-1:0]         PEAK_PWR;
    logic [LOGPTS-1:0]       PEAK_BIN;
    logic [SUMW-1:0]         PWR_SUM;
    logic [SEXPW-1:0]        PEAK_EXP;
    logic                    OVERRUN;

    int      n_checks = 0;
    int      n_pass   = 0;
    result_t sb_q[$];
    int      fr_re[POINTS];
    int      fr_im[POINTS];

    fft_peak_search #(
        .POINTS(POINTS),
        .WIDTH (WIDTH),
        .SEXPW (SEXPW)
    ) dut (
        .CLK        (CLK),
        .NGRST      (NGRST),
        .OUTP_READY (OUTP_READY),
        .READ_OUTP  (READ_OUTP),
        .DATAO_VALID(DATAO_VALID),
        .DATAO_RE   (DATAO_RE),
        .DATAO_IM   (DATAO_IM),
        .SCALE_EXP  (SCALE_EXP),
        .PEAK_VALID (PEAK_VALID),
        .PEAK_ACK   (PEAK_ACK),
        .PEAK_PWR   (PEAK_PWR),
        .PEAK_BIN   (PEAK_BIN),
        .PWR_SUM    (PWR_SUM),
        .PEAK_EXP   (PEAK_EXP),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_frame(input int re_all, input int im_all);
        for (int k = 0; k < POINTS; k++) begin
            fr_re[k] = re_all;
            fr_im[k] = im_all;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_outp"},  READ_OUTP,  0);
        check({tag, "_peak_valid"}, PEAK_VALID, 0);
        check({tag, "_peak_pwr"},   PEAK_PWR,   0);
        check({tag, "_peak_bin"},   PEAK_BIN,   0);
        check({tag, "_pwr_sum"},    PWR_SUM,    0);
        check({tag, "_peak_exp"},   PEAK_EXP,   0);
        check({tag, "_overrun"},    OVERRUN,    0);
    endtask

    // Raise OUTP_READY and wait (bounded) for the READ_OUTP pulse.
    task automatic request_frame(input string tag);
        logic seen;
        seen = 1'b0;
        OUTP_READY = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (READ_OUTP) seen = 1'b1;
        end
        check({tag, "_read_outp_seen"}, seen, 1);
        OUTP_READY = 1'b0;
    endtask

    // Drive fr_re/fr_im as one frame (optionally with random gaps), push the
    // expected result and check PEAK_VALID timing relative to the last bin.
    task automatic drive_bins(input string tag, input int gap_max, input int exp0, input int exp_rest);
        int      p;
        result_t r;
        r.pwr = 0;
        r.bin = 0;
        r.sum = 0;
        r.exp = exp0;
        for (int k = 0; k < POINTS; k++) begin
            p = fr_re[k] * fr_re[k] + fr_im[k] * fr_im[k];
            if (k == 0 || p > r.pwr) begin
                r.pwr = p;
                r.bin = k;
            end
            r.sum += p;
        end
        sb_q.push_back(r);

        for (int k = 0; k < POINTS; k++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    DATAO_VALID = 1'b0;
                    SCALE_EXP   = SEXPW'(exp_rest);
                    step();
                end
            end
            DATAO_VALID = 1'b1;
            DATAO_RE    = WIDTH'(fr_re[k]);
            DATAO_IM    = WIDTH'(fr_im[k]);
            SCALE_EXP   = SEXPW'((k == 0) ? exp0 : exp_rest);
            step();
            if (k == 0) check({tag, "_read_outp_width"}, READ_OUTP, 0);
        end
        DATAO_VALID = 1'b0;
        DATAO_RE    = '0;
        DATAO_IM    = '0;
        SCALE_EXP   = SEXPW'(exp_rest);
        check({tag, "_valid_t1"}, PEAK_VALID, 0);
        step();
        check({tag, "_valid_t2"}, PEAK_VALID, 0);
        step();
        check({tag, "_valid_t3"}, PEAK_VALID, 1);
    endtask

    // Wait (bounded) for PEAK_VALID and compare against the scoreboard head.
    task automatic wait_result(input string tag);
        result_t r;
        for (int i = 0; i < 20 && !PEAK_VALID; i++) step();
        check({tag, "_peak_valid"}, PEAK_VALID, 1);
        check({tag, "_sb_size"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check({tag, "_peak_pwr"}, PEAK_PWR, r.pwr);
            check({tag, "_peak_bin"}, PEAK_BIN, r.bin);
            check({tag, "_pwr_sum"},  PWR_SUM,  r.sum);
            check({tag, "_peak_exp"}, PEAK_EXP, r.exp);
        end
    endtask

    task automatic ack(input string tag);
        PEAK_ACK = 1'b1;
        step();
        PEAK_ACK = 1'b0;
        check({tag, "_ack_clears_valid"}, PEAK_VALID, 0);
    endtask

    initial begin
        NGRST       = 1'b0;
        OUTP_READY  = 1'b0;
        DATAO_VALID = 1'b0;
        DATAO_RE    = '0;
        DATAO_IM    = '0;
        SCALE_EXP   = '0;
        PEAK_ACK    = 1'b0;

        // Reset state.
        #2;
        check_all_zero("reset");
        step();
        step();
        NGRST = 1'b1;
        step();

        // Frame A: bin 3 = (100,0), others (1,1).
        set_frame(1, 1);
        fr_re[3] = 100;
        fr_im[3] = 0;
        request_frame("A");
        drive_bins("A", 0, 3, 3);
        wait_result("A");
        check("A_const_pwr", PEAK_PWR, 10000);
        check("A_const_sum", PWR_SUM, 10014);

        // Hold off ACK with OUTP_READY high: no new request, results held.
        OUTP_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_no_read_outp", READ_OUTP, 0);
            check("hold_valid", PEAK_VALID, 1);
        end
        ack("hold");
        check("hold_read_outp_a1", READ_OUTP, 0);
        check("hold_pwr_kept", PEAK_PWR, 10000);
        step();
        check("hold_read_outp_a2", READ_OUTP, 1);
        OUTP_READY = 1'b0;

        // Frame B (started by the READ_OUTP above): tie between bins 2 and 5.
        set_frame(0, 0);
        fr_im[2] = -50;
        fr_im[5] = -50;
        drive_bins("B", 0, 1, 1);
        wait_result("B");
        check("B_const_bin", PEAK_BIN, 2);
        check("B_const_sum", PWR_SUM, 5000);
        ack("B");

        // Frame C: full-scale negative bins, no overflow.
        set_frame(-128, -128);
        request_frame("C");
        drive_bins("C", 0, 15, 15);
        wait_result("C");
        check("C_const_pwr", PEAK_PWR, 32768);
        check("C_const_sum", PWR_SUM, 262144);
        ack("C");

        // Frame D: frame A data with random gaps; exponent changes after bin 0.
        set_frame(1, 1);
        fr_re[3] = 100;
        fr_im[3] = 0;
        request_frame("D");
        drive_bins("D", 3, 5, 9);
        wait_result("D");
        check("D_const_exp", PEAK_EXP, 5);
        ack("D");

        // Reset asserted at bin 4 of a large-valued frame.
        request_frame("R");
        for (int k = 0; k < 4; k++) begin
            DATAO_VALID = 1'b1;
            DATAO_RE    = 8'sd127;
            DATAO_IM    = -8'sd127;
            SCALE_EXP   = 4'd7;
            step();
        end
        DATAO_VALID = 1'b1;
        NGRST = 1'b0;
        #1;
        check_all_zero("midreset");
        DATAO_VALID = 1'b0;
        step();
        step();
        NGRST = 1'b1;
        step();
        check("postreset_no_read_outp", READ_OUTP, 0);

        // Frame E: only the new frame contributes.
        set_frame(2, -1);
        fr_re[6] = -7;
        fr_im[6] = 3;
        request_frame("E");
        drive_bins("E", 0, 2, 2);
        wait_result("E");
        ack("E");

        // Bin data while IDLE: sticky OVERRUN, data discarded.
        check("overrun_before", OVERRUN, 0);
        DATAO_VALID = 1'b1;
        DATAO_RE    = 8'sd127;
        DATAO_IM    = 8'sd127;
        step();
        DATAO_VALID = 1'b0;
        check("overrun_set", OVERRUN, 1);
        set_frame(0, 0);
        fr_im[2] = -50;
        fr_im[5] = -50;
        request_frame("F");
        drive_bins("F", 0, 4, 4);
        wait_result("F");
        check("overrun_sticky", OVERRUN, 1);
        ack("F");
        NGRST = 1'b0;
        #1;
        check("overrun_cleared", OVERRUN, 0);
        step();
        NGRST = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_peak_search.md
# fft_peak_search

Frame-level peak detector that sits directly downstream of the in-place CoreFFT output port. It requests each finished frame, squares and sums the complex output bins, and tracks the largest power and its bin index. At frame end it presents peak power, peak bin, summed power and the frame's scale exponent through a valid/ack handshake. This is the GNSS acquisition stage that turns an FFT frame into a correlation peak and a noise-floor estimate.

## Interface
- POINTS, 256, FFT frame length; power of two, 8..4096
- WIDTH, 18, FFT output component width (signed two's complement)
- SEXPW, 4, width of the SCALE_EXP input
- LOGPTS, derived, ceil_log2(POINTS); not overridden
- PWRW, derived, 2*WIDTH+1; power width
- SUMW, derived, PWRW+LOGPTS; sum width

Ports:
- CLK  in  1  single clock; all logic is rising-edge
- NGRST  in  1  asynchronous active-low reset
- OUTP_READY  in  1  FFT has a finished frame available
- READ_OUTP  out  1  one-cycle request to start FFT frame readout
- DATAO_VALID  in  1  DATAO_RE/IM carry one bin this cycle
- DATAO_RE  in  WIDTH  bin real part, signed
- DATAO_IM  in  WIDTH  bin imaginary part, signed
- SCALE_EXP  in  SEXPW  FFT block-scaling exponent for the frame
- PEAK_VALID  out  1  result registers valid; held until PEAK_ACK
- PEAK_ACK  in  1  consumer accepts the result
- PEAK_PWR  out  PWRW  largest re²+im² in the frame, unsigned
- PEAK_BIN  out  LOGPTS  bin index of PEAK_PWR
- PWR_SUM  out  SUMW  sum of re²+im² over all POINTS bins
- PEAK_EXP  out  SEXPW  SCALE_EXP captured for the frame
- OVERRUN  out  1  sticky error: DATAO_VALID seen outside COLLECT

## Operation
- Reset: every output is 0; the FSM enters IDLE; the bin counter and accumulators are cleared.
- FSM states:
  - IDLE: if OUTP_READY=1 and PEAK_VALID=0, assert READ_OUTP for exactly one cycle and go to COLLECT. Otherwise hold in IDLE.
  - COLLECT: each DATAO_VALID cycle takes one bin and increments bin counter k (0..POINTS-1). Gaps in DATAO_VALID are allowed. After bin POINTS-1 is accepted, go to FLUSH. OUTP_READY is ignored in this state.
  - FLUSH: drain the 2-stage pipe, then load the outputs, set PEAK_VALID=1 and go to DONE.
  - DONE: hold all outputs until PEAK_ACK=1. On ACK, clear PEAK_VALID next cycle and return to IDLE. All other outputs keep their last value.
- Arithmetic:
  - Stage 1 registers p = re*re + im*im as signed multiply products, summed unsigned into PWRW bits. Exact, no saturation; -2^(WIDTH-1) squared fits.
  - Stage 2: bin 0 loads the peak unconditionally. Later bins replace the peak only if p > peak, strictly, so on a tie the lowest index wins.
  - Stage 2 also adds p to the SUMW accumulator, which cannot overflow.
- SCALE_EXP is captured on the bin-0 DATAO_VALID cycle.
- OVERRUN sets when DATAO_VALID=1 in IDLE, FLUSH or DONE. That data is discarded. Only NGRST clears OVERRUN.
- A reset asserted mid-frame discards the partial frame. No READ_OUTP is issued until the state returns to IDLE and OUTP_READY=1.

## Timing
- READ_OUTP rises the cycle after IDLE sees OUTP_READY=1 with PEAK_VALID=0; pulse width is one cycle.
- Pipeline latency is 2 cycles from DATAO_VALID to peak/sum update.
- If the last bin is accepted at cycle t, PEAK_VALID=1 at t+3, together with stable PEAK_* outputs and PWR_SUM.
- PEAK_ACK at cycle a clears PEAK_VALID at a+1. The earliest next READ_OUTP is at a+2.
- PEAK_ACK while PEAK_VALID=0 is ignored.
- Throughput is one bin per cycle, with no backpressure on DATAO_*.

## Test plan
- POINTS=8, WIDTH=8: bin 3 = (100,0), all other bins = (1,1) -> PEAK_BIN=3, PEAK_PWR=10000, PWR_SUM=10014, PEAK_VALID 3 cycles after bin 7.
- Bins 2 and 5 = (0,-50), others 0 -> PEAK_BIN=2, PEAK_PWR=2500, PWR_SUM=5000.
- All bins = (-128,-128) -> PEAK_PWR=32768, PEAK_BIN=0, PWR_SUM=262144, no overflow.
- DATAO_VALID with random 0-3 cycle gaps, SCALE_EXP=5 at bin 0 then 9 -> same peak as the gapless run, PEAK_EXP=5.
- Hold PEAK_ACK low for 20 cycles with OUTP_READY high -> no READ_OUTP. ACK -> PEAK_VALID low next cycle, READ_OUTP the cycle after.
- NGRST low at bin 4, then a full new frame -> outputs 0 during reset, and the next result reflects only the new frame. DATAO_VALID in IDLE -> OVERRUN=1 until reset.
